// File: rtl/spi_sram_ctrl.sv
// Serial SPI SRAM controller: turns one byte/half/word load or store into a
// complete mode-0 READ (0x03) / WRITE (0x02) transaction with a 24-bit address.
module spi_sram_ctrl #(
  parameter int unsigned DIV    = 1,
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_done,
  output logic [31:0]       resp_rdata,
  output logic              sclk,
  output logic              sram_ce,
  output logic              si,
  input  logic              so
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = 7;
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {IDLE, SHIFT, CEHOLD} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BIT_W-1:0]   last_q, last_d;
  logic [63:0]        shreg_q, shreg_d;
  logic [31:0]        rx_q, rx_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               we_q, we_d;
  logic               sclk_q, sclk_d;
  logic               ce_q, ce_d;
  logic               si_q, si_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic [63:0]        stream;
  logic [BIT_W-1:0]   last_bit;
  logic [4:0]         rx_idx;

  // Outgoing bit stream, left aligned: cmd, address, then write data LSB byte first
  always_comb begin
    stream = {req_we ? CMD_WRITE : CMD_READ, 24'(req_addr), 32'h0};
    if (req_we) begin
      stream[31:0] = {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
    end
    case (req_size)
      2'd0:    last_bit = BIT_W'(39);
      2'd1:    last_bit = BIT_W'(47);
      default: last_bit = BIT_W'(63);
    endcase
  end

  // Data bit k (bit_q - 32) lands in byte k/8, MSB first within each byte
  assign rx_idx = {bit_q[4:3], ~bit_q[2:0]};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    sclk_d  = sclk_q;
    ce_d    = ce_q;
    si_d    = si_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          state_d = SHIFT;
          we_d    = req_we;
          last_d  = last_bit;
          si_d    = stream[63];
          shreg_d = {stream[62:0], 1'b0};
          div_d   = '0;
          bit_d   = '0;
          rx_d    = '0;
          sclk_d  = 1'b0;
          ce_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_W'(DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (!we_q && bit_q >= BIT_W'(32)) begin
              rx_d[rx_idx] = so;
            end
          end else begin
            sclk_d = 1'b0;
            if (bit_q == last_q) begin
              state_d = CEHOLD;
              si_d    = 1'b0;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              si_d    = shreg_q[63];
              shreg_d = {shreg_q[62:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      CEHOLD: begin
        if (div_q == DIV_W'(DIV - 1)) begin
          state_d = IDLE;
          div_d   = '0;
          ce_d    = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
          if (!we_q) begin
            rdata_d = rx_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      last_q  <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sclk_q  <= 1'b0;
      ce_q    <= 1'b1;
      si_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      sclk_q  <= sclk_d;
      ce_q    <= ce_d;
      si_q    <= si_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_done  = done_q;
  assign resp_rdata = rdata_q;
  assign sclk       = sclk_q;
  assign sram_ce    = ce_q;
  assign si         = si_q;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Bench for spi_sram_ctrl: SPI SRAM device models, a cycle-level reference of
// the pin/handshake behaviour, directed cases and randomized traffic.
`timescale 1ns/1ps
module tb_spi_sram_ctrl;

  localparam int unsigned DIV = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [1:0]  req_size  = 2'd0;
  logic [23:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_done;
  logic [31:0] resp_rdata;
  wire         sclk0, ce0, si0, so0;

  logic        v2 = 1'b0;
  logic [23:0] a2 = '0;
  logic        req_ready2, resp_done2;
  logic [31:0] resp_rdata2;
  wire         sclk1, ce1, si1, so1;

  int   n_chk = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  spi_sram_ctrl #(.DIV(1), .ADDR_W(24)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_rdata(resp_rdata),
    .sclk(sclk0), .sram_ce(ce0), .si(si0), .so(so0)
  );

  spi_sram_ctrl #(.DIV(2), .ADDR_W(24)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(req_ready2),
    .req_we(1'b0), .req_size(2'd2), .req_addr(a2), .req_wdata(32'h0),
    .resp_done(resp_done2), .resp_rdata(resp_rdata2),
    .sclk(sclk1), .sram_ce(ce1), .si(si1), .so(so1)
  );

  function automatic logic [7:0] init_byte(input logic [23:0] a);
    return 8'(a * 24'd37) ^ a[15:8] ^ 8'h5C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial SRAM device: 24-bit address, sequential mode wrapping at 0xFFFFFF
  for (genvar g = 0; g < 2; g++) begin : g_slv
    wire s_clk = (g == 0) ? sclk0 : sclk1;
    wire s_ce  = (g == 0) ? ce0   : ce1;
    wire s_si  = (g == 0) ? si0   : si1;
    logic [7:0]  mem [int unsigned];
    logic [31:0] hdr   = '0;
    logic [7:0]  wbyte = '0;
    logic        so_r  = 1'b0;
    int          cnt   = 0;
    int          rises = 0;

    always @(negedge s_ce or posedge s_ce) begin
      cnt  = 0;
      so_r = 1'b0;
      if (!s_ce) rises = 0;
    end

    always @(posedge s_clk) if (!s_ce) begin
      logic [23:0] a;
      rises++;
      if (cnt < 32) hdr = {hdr[30:0], s_si};
      else if (hdr[31:24] == 8'h02) begin
        wbyte = {wbyte[6:0], s_si};
        if ((cnt - 32) % 8 == 7) begin
          a = hdr[23:0] + 24'((cnt - 32) / 8);
          mem[32'(a)] = wbyte;
        end
      end
      cnt++;
    end

    always @(negedge s_clk) if (!s_ce && cnt >= 32 && hdr[31:24] == 8'h03) begin
      int k;
      logic [23:0] a;
      logic [7:0]  b;
      k = cnt - 32;
      a = hdr[23:0] + 24'(k / 8);
      b = mem.exists(32'(a)) ? mem[32'(a)] : init_byte(a);
      so_r = b[3'(7 - k % 8)];
    end
  end

  assign so0 = g_slv[0].so_r;
  assign so1 = g_slv[1].so_r;

  // Reference memory contents as the core sees them after each completed write
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : init_byte(a);
  endfunction

  // Reference model: t counts clocks since acceptance; done at 2*DIV*bits + DIV
  logic        m_active = 1'b0, m_done = 1'b0, m_we = 1'b0, m_acc = 1'b0;
  int          m_t = 0, m_lat = 0, m_bits = 0, m_n = 0;
  logic [63:0] m_stream = '0;
  logic [31:0] m_rdata = '0, m_pend = '0, m_wdata = '0;
  logic [23:0] m_addr = '0;

  always @(posedge clk or posedge reset) begin
    logic [23:0] ta;
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_acc    = 1'b0;
      m_rdata  = '0;
      m_t      = 0;
    end else begin
      m_done = 1'b0;
      m_acc  = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == m_lat) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          if (m_we) begin
            for (int i = 0; i < m_n; i++) begin
              ta = m_addr + 24'(i);
              ref_mem[32'(ta)] = m_wdata[8*i +: 8];
            end
          end else m_rdata = m_pend;
        end
      end else if (req_valid) begin
        m_acc    = 1'b1;
        m_active = 1'b1;
        m_t      = 0;
        m_we     = req_we;
        m_addr   = req_addr;
        m_wdata  = req_wdata;
        m_n      = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        m_bits   = 32 + 8 * m_n;
        m_lat    = 2 * DIV * m_bits + DIV;
        m_stream = {req_we ? 8'h02 : 8'h03, req_addr,
                    req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
        m_pend   = '0;
        for (int i = 0; i < m_n; i++) begin
          ta = req_addr + 24'(i);
          m_pend[8*i +: 8] = ref_rd(ta);
        end
      end
    end
  end

  // Per-cycle compare of all DIV=1 outputs against the model
  always @(negedge clk) if (chk_en) begin
    logic e_sclk, e_si;
    int   b;
    e_sclk = 1'b0;
    e_si   = 1'b0;
    if (m_active && m_t < 2 * DIV * m_bits) begin
      b      = m_t / (2 * DIV);
      e_sclk = (m_t % (2 * DIV)) >= DIV;
      if (b < 32 || m_we) e_si = m_stream[63 - b];
    end
    check("cycle", 64'({req_ready, resp_done, ce0, sclk0, si0, resp_rdata}),
                   64'({!m_active, m_done, !m_active, e_sclk, e_si, m_rdata}));
  end

  task automatic xact(input logic we, input logic [1:0] sz, input logic [23:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int w;
    req_we = we; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    w = 0;
    do begin @(posedge clk); #1; w++; end while (!m_acc && w < 2000);
    req_valid = 1'b0;
    check("accept", 64'(m_acc), 64'(1));
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!resp_done && lat < 2000);
    rd = resp_rdata;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp;
    logic [23:0] ta;
    int lat, c, acc_c, done_c, r1, r2;
    logic prev;

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_ce",    64'(ce0), 64'(1));
    check("rst_pins",  64'({sclk0, si0, resp_done}), 64'(0));
    check("rst_rdata", 64'(resp_rdata), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    xact(1'b1, 2'd2, 24'h000010, 32'hDEADBEEF, rd, lat);
    check("wr_word_lat", 64'(lat), 64'd129);
    check("wr_word_hdr", 64'(g_slv[0].hdr), 64'h0200_0010);
    check("wr_word_mem", 64'({g_slv[0].mem[32'h13], g_slv[0].mem[32'h12],
                              g_slv[0].mem[32'h11], g_slv[0].mem[32'h10]}), 64'hDEADBEEF);
    xact(1'b0, 2'd2, 24'h000010, 32'h0, rd, lat);
    check("rd_word_lat", 64'(lat), 64'd129);
    check("rd_word", 64'(rd), 64'hDEADBEEF);
    xact(1'b0, 2'd0, 24'h000011, 32'h0, rd, lat);
    check("rd_byte_lat", 64'(lat), 64'd81);
    check("rd_byte", 64'(rd), 64'h0000_00BE);
    xact(1'b0, 2'd1, 24'h000012, 32'h0, rd, lat);
    check("rd_half_lat", 64'(lat), 64'd97);
    check("rd_half", 64'(rd), 64'h0000_DEAD);

    xact(1'b1, 2'd0, 24'hFFFFFF, 32'hA5A5_A55A, rd, lat);
    check("wrap_wr_hdr", 64'(g_slv[0].hdr), 64'h02FF_FFFF);
    xact(1'b0, 2'd2, 24'hFFFFFF, 32'h0, rd, lat);
    check("wrap_rd_hdr", 64'(g_slv[0].hdr), 64'h03FF_FFFF);
    check("wrap_rd_b0", 64'(rd[7:0]), 64'h5A);

    // Request pulsed while busy, then one held until the done/ready cycle
    req_we = 1'b0; req_size = 2'd2; req_addr = 24'h000020; req_valid = 1'b1;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!m_acc && c < 100);
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 req_we = 1'b1; req_addr = 24'h000030; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1 req_we = 1'b0; req_size = 2'd1; req_addr = 24'h000010; req_valid = 1'b1;
    c = 0; acc_c = -1; done_c = -1;
    while (acc_c < 0 && c < 400) begin
      @(posedge clk); #1; c++;
      if (resp_done) begin
        done_c = c;
        check("gap_ce_high", 64'(ce0), 64'(1));
      end
      if (m_acc) acc_c = c;
    end
    req_valid = 1'b0;
    check("busy_accept_edge", 64'(acc_c - done_c), 64'(1));
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!resp_done && c < 400);
    check("busy_second_lat", 64'(c), 64'd97);
    check("busy_second_rd", 64'(resp_rdata), 64'h0000_BEEF);
    check("busy_ignored", 64'(g_slv[0].mem.exists(32'h30)), 64'(0));

    for (int i = 0; i < 40; i++) begin
      logic [23:0] a;
      logic [1:0]  sz;
      logic        we;
      int          n;
      a  = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 63))
                                       : 24'hFFFFF0 + 24'($urandom_range(0, 15));
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      exp = '0;
      for (int j = 0; j < n; j++) begin
        ta = a + 24'(j);
        exp[8*j +: 8] = ref_rd(ta);
      end
      xact(we, sz, a, $urandom, rd, lat);
      check("rand_lat", 64'(lat), 64'(2 * (32 + 8 * n) + 1));
      if (!we) check("rand_rdata", 64'(rd), 64'(exp));
    end

    // Asynchronous reset in the middle of a word write
    req_we = 1'b1; req_size = 2'd2; req_addr = 24'h000100; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!m_acc && c < 100);
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_ce", 64'(ce0), 64'(1));
    check("arst_sclk", 64'(sclk0), 64'(0));
    check("arst_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    exp = '0;
    for (int j = 0; j < 4; j++) begin
      ta = 24'(j);
      exp[8*j +: 8] = ref_rd(ta);
    end
    xact(1'b0, 2'd2, 24'h000000, 32'h0, rd, lat);
    check("arst_rd_lat", 64'(lat), 64'd129);
    check("arst_rd", 64'(rd), 64'(exp));
    check("arst_no_write", 64'(g_slv[0].mem.exists(32'h100)), 64'(0));

    // DIV=2 word read
    a2 = 24'h000040; v2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    check("div2_ce_low", 64'(ce1), 64'(0));
    c = 0; r1 = -1; r2 = -1; prev = sclk1;
    do begin
      @(posedge clk); #1; c++;
      if (sclk1 && !prev) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      prev = sclk1;
    end while (!resp_done2 && c < 1000);
    exp = '0;
    for (int j = 0; j < 4; j++) begin
      ta = 24'h000040 + 24'(j);
      exp[8*j +: 8] = init_byte(ta);
    end
    check("div2_lat", 64'(c), 64'd258);
    check("div2_period", 64'(r2 - r1), 64'd4);
    check("div2_rises", 64'(g_slv[1].rises), 64'd64);
    check("div2_rdata", 64'(resp_rdata2), 64'(exp));
    check("div2_ready", 64'(req_ready2), 64'(1));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
